// File: rtl/lifo_ram_ctrl_pkg.sv
// Shared state encoding and default geometry for the LIFO RAM controller.
// Default geometry is a 32 x 8 word RAM.
package lifo_ram_ctrl_pkg;

   localparam int LIFO_DW    = 8;
   localparam int LIFO_AW    = 5;
   localparam int LIFO_DEPTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } lifo_state_e;

endpackage

// File: rtl/lifo_sp_cnt.sv
// Stack pointer for the LIFO RAM controller: saturating up/down word count.
// It also decodes FULL and EMPTY from that count.
module lifo_sp_cnt
   import lifo_ram_ctrl_pkg::*;
#(
   parameter int AW    = LIFO_AW,
   parameter int DEPTH = LIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        dec,
   output logic [AW:0] count,
   output logic        full,
   output logic        empty
);

   logic [AW:0] count_q;
   logic [AW:0] count_d;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (inc && !full) begin
         count_d = count_q + 1'b1;
      end else if (dec && !empty) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/lifo_ram_ctrl.sv
// LIFO controller acting as initiator on the IO/W_S/W_EN/RWS/CS RAM bus.
// Define LIFO_PEEK_EN to add the PEEK request (read top without popping).
module lifo_ram_ctrl
   import lifo_ram_ctrl_pkg::*;
#(
   parameter int DW    = LIFO_DW,
   parameter int AW    = LIFO_AW,
   parameter int DEPTH = LIFO_DEPTH
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          PUSH,
   input  logic          POP,
`ifdef LIFO_PEEK_EN
   input  logic          PEEK,
`endif
   input  logic [DW-1:0] DIN,
   output logic [DW-1:0] DOUT,
   output logic          VALID,
   output logic          BUSY,
   output logic          FULL,
   output logic          EMPTY,
   output logic [AW:0]   COUNT,
   output logic          ERR,
   inout  wire  [DW-1:0] IO,
   output logic [AW-1:0] W_S,
   output logic          W_EN,
   output logic          RWS,
   output logic          CS
);

   lifo_state_e   state_q, state_d;
   logic [AW-1:0] ws_q, ws_d;
   logic          cs_q, cs_d;
   logic          wen_q, wen_d;
   logic          rws_q, rws_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          is_pop_q, is_pop_d;
   logic          inc, dec;
   logic          pop_ok, push_ok, peek_ok, peek_err;
   logic [AW-1:0] rd_addr;

   lifo_sp_cnt #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_sp (
      .clk   (CLK),
      .rst   (RST),
      .inc   (inc),
      .dec   (dec),
      .count (COUNT),
      .full  (FULL),
      .empty (EMPTY)
   );

`ifdef LIFO_PEEK_EN
   assign peek_ok  = PEEK && !EMPTY;
   assign peek_err = PEEK && EMPTY && !PUSH;
`else
   assign peek_ok  = 1'b0;
   assign peek_err = 1'b0;
`endif

   assign pop_ok  = POP && !EMPTY;
   assign push_ok = PUSH && !FULL;
   assign rd_addr = AW'(COUNT - 1'b1);

   // The controller owns the bus only while the write cycle is in flight.
   assign IO = (state_q == ST_WRITE) ? wdata_q : {DW{1'bz}};

   always_comb begin
      state_d  = state_q;
      ws_d     = ws_q;
      cs_d     = 1'b0;
      wen_d    = 1'b0;
      rws_d    = 1'b0;
      wdata_d  = wdata_q;
      dout_d   = dout_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      is_pop_d = is_pop_q;
      inc      = 1'b0;
      dec      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pop_ok || peek_ok) begin
               state_d  = ST_READ;
               ws_d     = rd_addr;
               cs_d     = 1'b1;
               wen_d    = 1'b1;
               is_pop_d = pop_ok;
            end else if (push_ok) begin
               state_d = ST_WRITE;
               ws_d    = COUNT[AW-1:0];
               cs_d    = 1'b1;
               wen_d   = 1'b1;
               rws_d   = 1'b1;
               wdata_d = DIN;
            end else begin
               err_d = (PUSH && FULL && !POP)
                     || (POP && EMPTY && !PUSH)
                     || peek_err;
            end
         end
         ST_WRITE: begin
            inc     = 1'b1;
            state_d = ST_IDLE;
         end
         ST_READ: begin
            dout_d  = IO;
            valid_d = 1'b1;
            dec     = is_pop_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         ws_q     <= '0;
         cs_q     <= 1'b0;
         wen_q    <= 1'b0;
         rws_q    <= 1'b0;
         wdata_q  <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         is_pop_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ws_q     <= ws_d;
         cs_q     <= cs_d;
         wen_q    <= wen_d;
         rws_q    <= rws_d;
         wdata_q  <= wdata_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         is_pop_q <= is_pop_d;
      end
   end

   assign BUSY  = (state_q != ST_IDLE);
   assign W_S   = ws_q;
   assign CS    = cs_q;
   assign W_EN  = wen_q;
   assign RWS   = rws_q;
   assign DOUT  = dout_q;
   assign VALID = valid_q;
   assign ERR   = err_q;

endmodule

// File: tb/tb_lifo_ram_ctrl.sv
// Bench for lifo_ram_ctrl: RAM model on the bus, stack model as a queue.
// Define LIFO_PEEK_EN to also exercise PEEK.
module tb_lifo_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       push, pop;
   logic [7:0] din;
   logic [7:0] dout;
   logic       valid, busy, full, empty, err;
   logic [5:0] count;
   wire  [7:0] io_bus;
   logic [4:0] w_s;
   logic       w_en, rws, cs;
`ifdef LIFO_PEEK_EN
   logic       peek;
`endif

   logic [7:0] mem [32];
   logic [7:0] model [$];
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   lifo_ram_ctrl dut (
      .CLK   (clk),
      .RST   (rst),
      .PUSH  (push),
      .POP   (pop),
`ifdef LIFO_PEEK_EN
      .PEEK  (peek),
`endif
      .DIN   (din),
      .DOUT  (dout),
      .VALID (valid),
      .BUSY  (busy),
      .FULL  (full),
      .EMPTY (empty),
      .COUNT (count),
      .ERR   (err),
      .IO    (io_bus),
      .W_S   (w_s),
      .W_EN  (w_en),
      .RWS   (rws),
      .CS    (cs)
   );

   // RAM array model
   assign io_bus = (cs && w_en && !rws) ? mem[w_s] : 8'bz;
   always @(posedge clk) begin
      if (cs && w_en && rws) mem[w_s] <= io_bus;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_status();
      chk("count", 32'(count), model.size());
      chk("full", 32'(full), 32'(model.size() == 32));
      chk("empty", 32'(empty), 32'(model.size() == 0));
   endtask

   // One request from IDLE; only the accepted request is dropped.
   task automatic op(input bit psh, input bit pp, input logic [7:0] d);
      int         n;
      bit         pop_ok, push_ok, err_e;
      logic [7:0] top;
      n       = model.size();
      pop_ok  = pp && n > 0;
      push_ok = !pop_ok && psh && n < 32;
      err_e   = (psh && n == 32 && !pp) || (pp && n == 0 && !psh);
      push = psh;
      pop  = pp;
      din  = d;
      @(posedge clk); #1;
      if (pop_ok) begin
         pop = 1'b0;
         chk("pop_cs", 32'(cs), 1);
         chk("pop_wen", 32'(w_en), 1);
         chk("pop_rws", 32'(rws), 0);
         chk("pop_ws", 32'(w_s), n - 1);
         chk("pop_busy", 32'(busy), 1);
         top = model.pop_back();
         @(posedge clk); #1;
         chk("pop_valid", 32'(valid), 1);
         chk("pop_dout", 32'(dout), 32'(top));
         chk("pop_cs_off", 32'(cs), 0);
      end else if (push_ok) begin
         push = 1'b0;
         chk("push_cs", 32'(cs), 1);
         chk("push_wen", 32'(w_en), 1);
         chk("push_rws", 32'(rws), 1);
         chk("push_ws", 32'(w_s), n);
         model.push_back(d);
         @(posedge clk); #1;
         chk("push_rws_off", 32'(rws), 0);
         chk("push_cs_off", 32'(cs), 0);
         chk("push_valid", 32'(valid), 0);
      end else begin
         push = 1'b0;
         pop  = 1'b0;
         chk("err", 32'(err), 32'(err_e));
         chk("idle_cs", 32'(cs), 0);
         chk("idle_busy", 32'(busy), 0);
      end
      chk_status();
   endtask

`ifdef LIFO_PEEK_EN
   task automatic peek_op();
      int n;
      n    = model.size();
      peek = 1'b1;
      @(posedge clk); #1;
      peek = 1'b0;
      if (n > 0) begin
         chk("peek_cs", 32'(cs), 1);
         chk("peek_rws", 32'(rws), 0);
         chk("peek_ws", 32'(w_s), n - 1);
         @(posedge clk); #1;
         chk("peek_valid", 32'(valid), 1);
         chk("peek_dout", 32'(dout), 32'(model[n-1]));
      end else begin
         chk("peek_err", 32'(err), 1);
         chk("peek_cs_off", 32'(cs), 0);
      end
      chk_status();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      push = 1'b0;
      pop  = 1'b0;
      din  = '0;
`ifdef LIFO_PEEK_EN
      peek = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_cs", 32'(cs), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_err", 32'(err), 0);
      rst = 1'b0;

      op(1, 0, 8'hA5);
      void'(model.pop_back());
      rst = 1'b1;
      #1 rst = 1'b0;
      chk_status();

      op(1, 0, 8'h11);
      op(1, 0, 8'h22);
      op(1, 0, 8'h33);
      repeat (3) op(0, 1, 8'h00);

      for (int i = 0; i < 32; i++) op(1, 0, 8'(i));
      op(1, 0, 8'hEE);
      op(0, 1, 8'h00);
      while (model.size() > 0) op(0, 1, 8'h00);

      op(0, 1, 8'h00);
      op(1, 0, 8'h01);
      op(1, 0, 8'h02);
      op(1, 1, 8'h03);
      op(1, 0, 8'h03);
      op(1, 1, 8'h00);
      op(1, 1, 8'h00);
      op(1, 1, 8'h77);

      // reset in the middle of a write cycle
      push = 1'b1;
      din  = 8'hC3;
      @(posedge clk); #1;
      push = 1'b0;
      chk("mid_cs_on", 32'(cs), 1);
      #1 rst = 1'b1;
      #1;
      model.delete();
      chk("mid_rst_cs", 32'(cs), 0);
      chk("mid_rst_wen", 32'(w_en), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk_status();
      #1 rst = 1'b0;
      op(1, 0, 8'h5C);

`ifdef LIFO_PEEK_EN
      op(0, 1, 8'h00);
      peek_op();
      op(1, 0, 8'h5A);
      peek_op();
      op(0, 1, 8'h00);
`endif

      for (int i = 0; i < 150; i++) begin
         op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom));
`ifdef LIFO_PEEK_EN
         if ($urandom_range(0, 7) == 0) peek_op();
`endif
      end
      while (model.size() < 32) op(1, 0, 8'($urandom));
      op(1, 0, 8'h99);
      while (model.size() > 0) op(0, 1, 8'h00);
      op(0, 1, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
